// File: rtl/encoder_proj_pkg.sv
// Shared definitions for the encoder_proj / decoder_proj code-word link.
// Holds the code-word field layout, the request/index widths, the frame
// state enum and the index parity helper.
package encoder_proj_pkg;

    localparam int unsigned N_REQ      = 8;
    localparam int unsigned IDX_W      = 3;
    localparam int unsigned SEQ_W      = 2;
    localparam int unsigned HOLD_W     = 4;
    localparam int unsigned CODE_W     = 7;

    localparam int unsigned STROBE_BIT = 6;
    localparam int unsigned SEQ_LSB    = 4;
    localparam int unsigned PAR_BIT    = 3;
    localparam int unsigned IDX_LSB    = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        GAP    = 2'd2
    } state_t;

    // Code word as it appears on the pads, MSB first: strobe, seq, parity, index.
    typedef struct packed {
        logic             strobe;
        logic [SEQ_W-1:0] seq;
        logic             par;
        logic [IDX_W-1:0] idx;
    } code_t;

    // Parity bit that makes {parity, idx} an even-weight nibble.
    function automatic logic idx_parity(input logic [IDX_W-1:0] idx);
        return ^idx;
    endfunction

endpackage

// File: rtl/encoder_proj_rr_arbiter.sv
// enc_rr_arbiter: combinational round-robin picker.
// Ports:
//   pending   - request bitmap to choose from
//   ptr       - highest-priority position; search runs upward and wraps 7->0
//   gnt_valid - some pending bit is set
//   gnt_idx   - index of the first set bit found from ptr
module enc_rr_arbiter
    import encoder_proj_pkg::*;
(
    input  logic [N_REQ-1:0] pending,
    input  logic [IDX_W-1:0] ptr,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_idx
);

    logic [IDX_W-1:0] cand;

    // Walk the eight positions starting at ptr; the index adder wraps naturally.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = ptr + IDX_W'(i);
            if (!gnt_valid && pending[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/encoder_proj.sv
// encoder_proj: latches request pulses, arbitrates them round-robin and
// sends one strobed 7-bit code word per grant on the io pads.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   en_i       - transmitter enable; gates new grants and drives io_oeb
//   req_i      - request pulses, OR-ed into the pending register
//   io_out     - code word {strobe, seq[1:0], parity, idx[2:0]}
//   io_oeb     - pad output enable, active-low
//   pending_o  - pending-request register
//   busy_o     - frame in progress
module encoder_proj
    import encoder_proj_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic [N_REQ-1:0]  req_i,
    output logic [CODE_W-1:0] io_out,
    output logic [CODE_W-1:0] io_oeb,
    output logic [N_REQ-1:0]  pending_o,
    output logic              busy_o
);

    state_t            state, state_nx;
    logic [HOLD_W-1:0] hold_cnt, hold_nx;
    logic [SEQ_W-1:0]  seq, seq_nx;
    logic [IDX_W-1:0]  ptr, ptr_nx;
    code_t             code, code_nx;
    logic [N_REQ-1:0]  pending_nx;
    logic [N_REQ-1:0]  clr_mask_c;
    logic              gnt_valid_c;
    logic [IDX_W-1:0]  gnt_idx_c;

    enc_rr_arbiter u_arb (
        .pending   (pending_o),
        .ptr       (ptr),
        .gnt_valid (gnt_valid_c),
        .gnt_idx   (gnt_idx_c)
    );

    // Next-state, frame word and pending update.
    always_comb begin
        state_nx   = state;
        hold_nx    = hold_cnt;
        seq_nx     = seq;
        ptr_nx     = ptr;
        code_nx    = code;
        clr_mask_c = '0;

        case (state)
            IDLE: begin
                code_nx.strobe = 1'b0;
                if (en_i && gnt_valid_c) begin
                    clr_mask_c     = N_REQ'(1) << gnt_idx_c;
                    ptr_nx         = gnt_idx_c + IDX_W'(1);
                    code_nx.strobe = 1'b1;
                    code_nx.seq    = seq;
                    code_nx.par    = idx_parity(gnt_idx_c);
                    code_nx.idx    = gnt_idx_c;
                    hold_nx        = HOLD_W'(HOLD_CYCLES - 1);
                    state_nx       = STROBE;
                end
            end
            STROBE: begin
                if (hold_cnt != '0) begin
                    hold_nx = hold_cnt - HOLD_W'(1);
                end else begin
                    code_nx.strobe = 1'b0;
                    seq_nx         = seq + SEQ_W'(1);
                    state_nx       = GAP;
                end
            end
            GAP: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        // A request landing on the bit being cleared keeps it set.
        pending_nx = (pending_o & ~clr_mask_c) | req_i;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            hold_cnt  <= '0;
            seq       <= '0;
            ptr       <= '0;
            code      <= '0;
            pending_o <= '0;
            io_oeb    <= {CODE_W{1'b1}};
            busy_o    <= 1'b0;
        end else begin
            state     <= state_nx;
            hold_cnt  <= hold_nx;
            seq       <= seq_nx;
            ptr       <= ptr_nx;
            code      <= code_nx;
            pending_o <= pending_nx;
            io_oeb    <= {CODE_W{~en_i}};
            busy_o    <= (state_nx != IDLE);
        end
    end

    assign io_out = code;

endmodule

// File: tb/tb_encoder_proj.sv
// Directed testbench for encoder_proj: hand-computed code words for
// single, multi-bit, repeated and colliding requests, enable gating and
// asynchronous reset.
module tb_encoder_proj;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en_i;
    logic [7:0] req_i;
    logic [6:0] io_out;
    logic [6:0] io_oeb;
    logic [7:0] pending_o;
    logic       busy_o;

    int n_vec = 0;
    int n_err = 0;

    encoder_proj #(.HOLD_CYCLES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_i      (en_i),
        .req_i     (req_i),
        .io_out    (io_out),
        .io_oeb    (io_oeb),
        .pending_o (pending_o),
        .busy_o    (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One rising edge, then settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en_i  = 1'b0;
        req_i = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_io_out", 32'(io_out), 32'h00);
        check_eq("rst_io_oeb", 32'(io_oeb), 32'h7F);
        check_eq("rst_pending", 32'(pending_o), 32'h00);
        check_eq("rst_busy", 32'(busy_o), 32'h0);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [6:0] exp_word;
        logic [1:0] sq;

        // Single request on bit 5.
        do_reset();
        en_i  = 1'b1;
        req_i = 8'h20;
        step();
        check_eq("t1_pend_set", 32'(pending_o), 32'h20);
        check_eq("t1_no_strobe", 32'(io_out[6]), 32'h0);
        check_eq("t1_oeb_on", 32'(io_oeb), 32'h00);
        req_i = 8'h00;
        step();
        check_eq("t1_word", 32'(io_out), 32'(7'b1000101));
        check_eq("t1_pend_clr", 32'(pending_o), 32'h00);
        check_eq("t1_busy", 32'(busy_o), 32'h1);
        step();
        check_eq("t1_hold", 32'(io_out), 32'(7'b1000101));
        step();
        check_eq("t1_gap", 32'(io_out), 32'(7'b0000101));
        check_eq("t1_gap_busy", 32'(busy_o), 32'h1);
        step();
        check_eq("t1_idle_busy", 32'(busy_o), 32'h0);
        check_eq("t1_idle_word", 32'(io_out), 32'(7'b0000101));

        // Two requests in one cycle, ptr at 0: idx 0 then idx 7.
        do_reset();
        en_i  = 1'b1;
        req_i = 8'h81;
        step();
        req_i = 8'h00;
        step();
        check_eq("t2_idx0", 32'(io_out), 32'(7'b1000000));
        check_eq("t2_pend", 32'(pending_o), 32'h80);
        step();
        step();
        step();
        check_eq("t2_space", 32'(io_out), 32'(7'b0000000));
        step();
        check_eq("t2_idx7", 32'(io_out), 32'(7'b1011111));
        check_eq("t2_pend0", 32'(pending_o), 32'h00);

        // Five frames on bit 3: seq wraps 3 -> 0.
        do_reset();
        en_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            req_i = 8'h08;
            step();
            req_i = 8'h00;
            step();
            sq       = 2'(k);
            exp_word = {1'b1, sq, 4'b0011};
            check_eq($sformatf("t3_seq%0d", k), 32'(io_out), 32'(exp_word));
            step();
            step();
            step();
        end

        // Enable gating.
        do_reset();
        req_i = 8'h04;
        step();
        req_i = 8'h00;
        step();
        check_eq("t4_no_strobe", 32'(io_out), 32'h00);
        check_eq("t4_pend", 32'(pending_o), 32'h04);
        check_eq("t4_oeb_off", 32'(io_oeb), 32'h7F);
        check_eq("t4_idle", 32'(busy_o), 32'h0);
        en_i = 1'b1;
        step();
        check_eq("t4_oeb_on", 32'(io_oeb), 32'h00);
        check_eq("t4_word", 32'(io_out), 32'(7'b1001010));

        // Request on the bit being granted survives the clear.
        do_reset();
        en_i  = 1'b1;
        req_i = 8'h10;
        step();
        step();
        check_eq("t5_word1", 32'(io_out), 32'(7'b1001100));
        check_eq("t5_pend_kept", 32'(pending_o), 32'h10);
        req_i = 8'h00;
        step();
        step();
        step();
        check_eq("t5_gap", 32'(io_out[6]), 32'h0);
        step();
        check_eq("t5_word2", 32'(io_out), 32'(7'b1011100));
        check_eq("t5_pend0", 32'(pending_o), 32'h00);

        // Asynchronous reset mid-STROBE.
        req_i = 8'hFF;
        step();
        check_eq("t6_strobe", 32'(io_out), 32'(7'b1011100));
        check_eq("t6_pend", 32'(pending_o), 32'hFF);
        rst_n = 1'b0;
        #1;
        check_eq("t6_io_out", 32'(io_out), 32'h00);
        check_eq("t6_busy", 32'(busy_o), 32'h0);
        check_eq("t6_pending", 32'(pending_o), 32'h00);
        check_eq("t6_oeb", 32'(io_oeb), 32'h7F);
        req_i = 8'h00;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/encoder_proj.md
Name: encoder_proj

Overview:
- Transmit-side counterpart of decoder_proj.
- Collects request pulses on 8 lines and arbitrates them round-robin.
- Encodes each grant into the 7-bit strobed code word that decoder_proj consumes on io_in.
- Drives that word on the user-project io pads (io_out/io_oeb), one frame per grant.

Parameters:
- N_REQ, 8, number of request lines; fixed at 8 because the index field is 3 bits.
- IDX_W, 3, index field width; equals clog2(N_REQ), not to be overridden.
- HOLD_CYCLES, 2, cycles the strobe stays high per frame; legal range 1..15.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en_i  input  1  transmitter enable.
- req_i  input  8  request pulses; a 1 on bit k marks request k pending.
- io_out  output  7  code word: [6] strobe, [5:4] seq, [3] parity, [2:0] index.
- io_oeb  output  7  pad output-enable, active-low.
- pending_o  output  8  current pending-request register.
- busy_o  output  1  high while a frame is in progress (state != IDLE).

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: io_out=7'h00, io_oeb=7'h7F, pending_o=8'h00, busy_o=0, rr pointer=0, seq=0, state=IDLE.
- Reset mid-frame aborts the frame immediately; no partial word persists.
- All outputs are registered.
- Pending register, every cycle:
  - pending <= (pending & ~clr_mask) | req_i.
  - clr_mask is one-hot of the bit granted this cycle, else 0.
  - A new request on the bit being cleared in the same cycle wins, so the bit stays set.
- Round-robin arbitration:
  - Search pending from bit ptr upward, wrapping 7->0; the first set bit is granted.
  - On grant, ptr <= (granted+1) mod 8. ptr changes only on grant.
- io_oeb <= {7{~en_i}}, one cycle after en_i changes.
- State machine IDLE / STROBE / GAP:
  - IDLE: if en_i && |pending:
    - grant index g, clear pending[g];
    - io_out <= {1'b1, seq, ^g, g}, where ^g is the parity bit making the 4-bit {parity,g} even;
    - hold counter <= HOLD_CYCLES-1; go STROBE.
  - IDLE otherwise: io_out[6] stays 0, lower bits hold their last value.
  - STROBE: while the counter is nonzero, decrement it and hold io_out. At zero: io_out[6] <= 0, seq <= seq+1 (mod 4, 3 wraps to 0), go GAP.
  - GAP: exactly 1 cycle with strobe low and the code held; then go IDLE.
  - A new grant can be made on the cycle IDLE is re-entered.
- Latency: a req_i pulse sampled at edge t sets pending at t. With an idle FSM and en_i high, the grant is made and the strobe appears on io_out after edge t+1. Strobe is high for HOLD_CYCLES cycles; back-to-back frames are spaced HOLD_CYCLES+2 cycles apart.
- en_i deasserted mid-frame: the current frame completes. No new grant while en_i is low; pending keeps accumulating.
- Requests arriving while busy are latched and served later in round-robin order.
- req_i with multiple bits set in one cycle: all bits latch.

Decomposition:
- Shared package encoder_proj_pkg, also imported by decoder_proj:
  - field positions STROBE_BIT=6, SEQ_LSB=4, PAR_BIT=3, IDX_LSB=0;
  - N_REQ, IDX_W;
  - state enum {IDLE, STROBE, GAP};
  - a parity helper function.
- One sub-module, enc_rr_arbiter: inputs pending[7:0], ptr[2:0]; outputs gnt_valid, gnt_idx[2:0]. Purely combinational. The pointer register lives in the parent.

Test Plan:
- Reset, then en_i=1 and a 1-cycle pulse req_i=8'h20 -> two edges later io_out=7'b1000101 (strobe, seq 0, parity 0, idx 5), held 2 cycles. Then io_out=7'b0000101, and pending_o=0 after the grant.
- req_i=8'h81 in one cycle, ptr=0 -> frames in order idx 0 (io_out=7'b1000000), then idx 7 with seq=1 (7'b1011111). Frames spaced 4 cycles apart.
- Five consecutive single requests on bit 3 -> seq field runs 0,1,2,3,0 (wrap), parity=0, word[3:0]=4'b0011 every frame.
- en_i=0 with req_i=8'h04 -> no strobe, pending_o=8'h04, io_oeb=7'h7F. Raise en_i -> io_oeb=7'h00 after one edge and the idx 2 frame starts.
- Frame active on idx 4 while req_i pulses bit 4 on the grant cycle -> pending_o[4] remains 1 and a second idx 4 frame follows.
- Assert rst_n=0 mid-STROBE -> io_out=0, busy_o=0, pending_o=0 immediately, without waiting for a clock edge.
